// File: rtl/rtc_timer_pkg.sv
// Shared widths, time-of-day payload type and the ns/sec rollover helper
// for the IEEE 1588 real-time clock.
package rtc_timer_pkg;

    localparam int unsigned NS_W      = 38;
    localparam int unsigned SEC_W     = 48;
    localparam int unsigned PER_W     = 40;
    localparam int unsigned DS_W      = 24;
    localparam int unsigned FRAC_NS_W = 8;
    localparam int unsigned ADJ_CNT_W = 32;
    localparam int unsigned STEP_W    = PER_W - DS_W;

    localparam logic [NS_W-1:0] NS_MODULO_1S = 38'd256_000_000_000;

    typedef struct packed {
        logic [SEC_W-1:0] sec;
        logic [NS_W-1:0]  ns;
    } rtc_time_t;

    // Advance time of day by one step, rolling ns into sec at the modulo.
    function automatic rtc_time_t time_advance(input rtc_time_t        cur,
                                               input logic [STEP_W-1:0] step,
                                               input logic [NS_W-1:0]   modulo);
        logic [NS_W:0] sum;
        rtc_time_t     nxt;
        nxt = cur;
        sum = {1'b0, cur.ns} + (NS_W+1)'(step);
        if (sum >= {1'b0, modulo}) begin
            nxt.ns  = NS_W'(sum - {1'b0, modulo});
            nxt.sec = cur.sec + SEC_W'(1);
        end else begin
            nxt.ns  = NS_W'(sum);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rtc_timer_if.sv
// Register-block side of the RTC: load strobes, programmed values and the
// running time of day.
interface rtc_timer_if;
    import rtc_timer_pkg::*;

    logic                 time_ld;
    logic [NS_W-1:0]      time_reg_ns_in;
    logic [SEC_W-1:0]     time_reg_sec_in;
    logic                 period_ld;
    logic [PER_W-1:0]     period_in;
    logic [NS_W-1:0]      time_acc_modulo;
    logic                 adj_ld;
    logic [ADJ_CNT_W-1:0] adj_ld_data;
    logic [PER_W-1:0]     period_adj;
    logic [NS_W-1:0]      time_reg_ns;
    logic [SEC_W-1:0]     time_reg_sec;

    modport master (
        output time_ld, time_reg_ns_in, time_reg_sec_in,
        output period_ld, period_in, time_acc_modulo,
        output adj_ld, adj_ld_data, period_adj,
        input  time_reg_ns, time_reg_sec
    );

    modport slave (
        input  time_ld, time_reg_ns_in, time_reg_sec_in,
        input  period_ld, period_in, time_acc_modulo,
        input  adj_ld, adj_ld_data, period_adj,
        output time_reg_ns, time_reg_sec
    );

endinterface

// File: rtl/rtc_delta_sigma.sv
// First-order delta-sigma on the low 24 period bits: emits the per-cycle
// step in 1/256 ns, carrying the sub-LSB fraction cycle to cycle.
module rtc_delta_sigma
    import rtc_timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PER_W-1:0]  inc,
    output logic [STEP_W-1:0] step_c
);

    logic [DS_W-1:0] ds_q;
    logic [DS_W:0]   sum_c;

    assign sum_c  = {1'b0, ds_q} + {1'b0, inc[DS_W-1:0]};
    assign step_c = inc[PER_W-1:DS_W] + STEP_W'(sum_c[DS_W]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ds_q <= '0;
        end else begin
            ds_q <= sum_c[DS_W-1:0];
        end
    end

endmodule

// File: rtl/rtc_timer.sv
// IEEE 1588 time-of-day counter: programmable period plus a time-limited
// adjustment, accumulated into 48-bit seconds and 38-bit ns.frac.
module rtc_timer
    import rtc_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    rtc_timer_if.slave  bus
);

    logic [PER_W-1:0]     period_q;
    logic [PER_W-1:0]     adj_q;
    logic [ADJ_CNT_W-1:0] adj_cnt_q;
    logic [PER_W-1:0]     adj_term_c;
    logic [PER_W-1:0]     inc_c;
    logic [STEP_W-1:0]    step_c;
    rtc_time_t            time_q;
    rtc_time_t            time_nxt_c;

    // Adjustment contributes only while its cycle count is still running.
    assign adj_term_c = (adj_cnt_q != '0) ? adj_q : '0;
    assign inc_c      = period_q + adj_term_c;

    rtc_delta_sigma u_ds (
        .clk    (clk),
        .rst    (rst),
        .inc    (inc_c),
        .step_c (step_c)
    );

    assign time_nxt_c = time_advance(time_q, step_c, bus.time_acc_modulo);

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q  <= '0;
            adj_q     <= '0;
            adj_cnt_q <= '0;
        end else begin
            if (bus.period_ld) begin
                period_q <= bus.period_in;
            end
            if (bus.adj_ld) begin
                adj_q     <= bus.period_adj;
                adj_cnt_q <= bus.adj_ld_data;
            end else if (adj_cnt_q != '0) begin
                adj_cnt_q <= adj_cnt_q - ADJ_CNT_W'(1);
            end
        end
    end

    // A software time load overrides the increment, including any rollover.
    always_ff @(posedge clk) begin
        if (rst) begin
            time_q <= '0;
        end else if (bus.time_ld) begin
            time_q.ns  <= bus.time_reg_ns_in;
            time_q.sec <= bus.time_reg_sec_in;
        end else begin
            time_q <= time_nxt_c;
        end
    end

    assign bus.time_reg_ns  = time_q.ns;
    assign bus.time_reg_sec = time_q.sec;

endmodule

// File: tb/tb_rtc_timer.sv
// Self-checking bench for rtc_timer: directed scenarios with literal
// expectations plus randomized traffic against an arithmetic model.
module tb_rtc_timer;

    localparam logic [37:0] MOD_1S = 38'd256_000_000_000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en   = 1'b0;

    rtc_timer_if bus ();

    rtc_timer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [39:0] period;
        logic [39:0] adj;
        logic [31:0] cnt;
        logic [23:0] ds;
        logic [37:0] ns;
        logic [47:0] sec;
    } model_t;

    model_t m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: fractional ns accumulate as a plain sum; whole 1/256-ns units
    // leave the 2^-24 remainder and are added to time, rolling at the modulo.
    function automatic model_t model_next(input model_t c);
        model_t            n;
        logic [39:0]       inc;
        longint unsigned   acc;
        longint unsigned   step;
        longint unsigned   s;
        n = c;
        if (rst) return '0;
        inc  = c.period + ((c.cnt != 0) ? c.adj : 40'd0);
        acc  = 64'(c.ds) + 64'(inc);
        step = (acc >> 24) % 64'h1_0000;
        n.ds = 24'(acc % 64'h100_0000);
        if (bus.time_ld) begin
            n.ns  = bus.time_reg_ns_in;
            n.sec = bus.time_reg_sec_in;
        end else begin
            s = 64'(c.ns) + step;
            if (s >= 64'(bus.time_acc_modulo)) begin
                n.ns  = 38'(s - 64'(bus.time_acc_modulo));
                n.sec = c.sec + 48'd1;
            end else begin
                n.ns = 38'(s);
            end
        end
        if (bus.period_ld) n.period = bus.period_in;
        if (bus.adj_ld) begin
            n.adj = bus.period_adj;
            n.cnt = bus.adj_ld_data;
        end else if (c.cnt != 0) begin
            n.cnt = c.cnt - 32'd1;
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m);

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ns",  64'(bus.time_reg_ns),  64'(m.ns));
            check("model_sec", 64'(bus.time_reg_sec), 64'(m.sec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.time_ld   = 1'b0;
        bus.period_ld = 1'b0;
        bus.adj_ld    = 1'b0;
    endtask

    task automatic clear_inputs();
        bus.time_ld         = 1'b0;
        bus.time_reg_ns_in  = '0;
        bus.time_reg_sec_in = '0;
        bus.period_ld       = 1'b0;
        bus.period_in       = '0;
        bus.time_acc_modulo = MOD_1S;
        bus.adj_ld          = 1'b0;
        bus.adj_ld_data     = '0;
        bus.period_adj      = '0;
    endtask

    task automatic randomize_inputs();
        bus.time_ld         = ($urandom_range(0, 29) == 0);
        bus.time_reg_ns_in  = 38'({$urandom, $urandom});
        bus.time_reg_sec_in = 48'({$urandom, $urandom});
        bus.period_ld       = ($urandom_range(0, 19) == 0);
        bus.period_in       = {8'($urandom_range(0, 15)), 32'($urandom)};
        bus.adj_ld          = ($urandom_range(0, 24) == 0);
        bus.adj_ld_data     = 32'($urandom_range(0, 20));
        bus.period_adj      = {8'($urandom_range(0, 3)), 32'($urandom)};
        if ($urandom_range(0, 49) == 0) begin
            case ($urandom_range(0, 5))
                0:       bus.time_acc_modulo = '0;
                1, 2:    bus.time_acc_modulo = 38'(32'h2000 + $urandom_range(0, 32'h0FFF_FFFF));
                default: bus.time_acc_modulo = MOD_1S;
            endcase
        end
    endtask

    logic [37:0] prev;
    logic [37:0] d;
    logic [37:0] last_d;
    logic [63:0] total;
    int          n21;

    initial begin
        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            randomize_inputs();
            tick();
            chk_en = 1'b1;
        end
        check("rst_ns",  64'(bus.time_reg_ns),  64'd0);
        check("rst_sec", 64'(bus.time_reg_sec), 64'd0);

        rst = 1'b0;
        clear_inputs();
        repeat (3) tick();
        check("idle_ns",  64'(bus.time_reg_ns),  64'd0);
        check("idle_sec", 64'(bus.time_reg_sec), 64'd0);

        // Period 8.0 ns, time zeroed in the same cycle.
        bus.period_ld = 1'b1; bus.period_in = 40'h08_0000_0000;
        bus.time_ld   = 1'b1; bus.time_reg_ns_in = '0; bus.time_reg_sec_in = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            prev = bus.time_reg_ns; tick(); d = bus.time_reg_ns - prev;
            check("p8_step", 64'(d), 64'h800);
        end
        check("p8_frac", 64'(bus.time_reg_ns[7:0]), 64'd0);

        // Load near the 1 s boundary and cross it.
        bus.time_ld = 1'b1; bus.time_reg_ns_in = 38'd255_999_997_440; bus.time_reg_sec_in = 48'd10;
        tick();
        check("ld_ns",    64'(bus.time_reg_ns),  64'd255_999_997_440);
        check("ld_sec",   64'(bus.time_reg_sec), 64'd10);
        tick();
        check("pre_ns",   64'(bus.time_reg_ns),  64'd255_999_999_488);
        check("pre_sec",  64'(bus.time_reg_sec), 64'd10);
        tick();
        check("roll_ns",  64'(bus.time_reg_ns),  64'd1536);
        check("roll_sec", 64'(bus.time_reg_sec), 64'd11);

        // Fractional period with coincident time and period loads.
        bus.period_ld = 1'b1; bus.period_in = 40'h08_1020_0000;
        bus.time_ld   = 1'b1; bus.time_reg_ns_in = '0; bus.time_reg_sec_in = '0;
        tick();
        check("both_ld_ns", 64'(bus.time_reg_ns), 64'd0);
        total = '0;
        for (int i = 0; i < 16; i++) begin
            prev = bus.time_reg_ns; tick(); d = bus.time_reg_ns - prev;
            total += 64'(d);
            check("frac_step", 64'(d), (i % 8 == 7) ? 64'h811 : 64'h810);
        end
        check("frac_total", total, 64'd33026);

        bus.period_ld = 1'b1; bus.period_in = 40'h08_0000_0000;
        tick();
        tick();

        // Ten-cycle adjustment with a half-LSB fraction.
        bus.adj_ld = 1'b1; bus.adj_ld_data = 32'd10; bus.period_adj = 40'h02_2080_0000;
        tick();
        n21 = 0;
        last_d = '0;
        for (int i = 0; i < 10; i++) begin
            prev = bus.time_reg_ns; tick(); d = bus.time_reg_ns - prev;
            if (d == 38'hA21) n21++;
            check("adj_step", 64'(d == 38'hA20 || d == 38'hA21), 64'd1);
            if (i > 0) check("adj_alt", 64'(d != last_d), 64'd1);
            last_d = d;
        end
        check("adj_carries", 64'(n21), 64'd5);
        prev = bus.time_reg_ns; tick(); d = bus.time_reg_ns - prev;
        check("adj_end", 64'(d), 64'h800);

        // Reload mid-adjustment restarts the count with the new value.
        bus.adj_ld = 1'b1; bus.adj_ld_data = 32'd6; bus.period_adj = 40'h02_0000_0000;
        tick();
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin
                bus.adj_ld = 1'b1; bus.adj_ld_data = 32'd4; bus.period_adj = 40'h01_0000_0000;
            end
            prev = bus.time_reg_ns; tick(); d = bus.time_reg_ns - prev;
            check("reload_step", 64'(d), (i <= 3) ? 64'hA00 : (i <= 7) ? 64'h900 : 64'h800);
        end

        // Time load on the cycle that would otherwise roll over.
        bus.time_ld = 1'b1; bus.time_reg_ns_in = MOD_1S - 38'h100; bus.time_reg_sec_in = 48'd20;
        tick();
        bus.time_ld = 1'b1; bus.time_reg_ns_in = 38'h500; bus.time_reg_sec_in = 48'd30;
        tick();
        check("ldroll_ns",  64'(bus.time_reg_ns),  64'h500);
        check("ldroll_sec", 64'(bus.time_reg_sec), 64'd30);
        tick();
        check("after_ld_ns", 64'(bus.time_reg_ns), 64'hD00);

        // Seconds wrap at 2^48.
        bus.time_ld = 1'b1; bus.time_reg_ns_in = MOD_1S - 38'h800; bus.time_reg_sec_in = 48'hFFFF_FFFF_FFFF;
        tick();
        tick();
        check("secwrap_ns",  64'(bus.time_reg_ns),  64'd0);
        check("secwrap_sec", 64'(bus.time_reg_sec), 64'd0);

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            randomize_inputs();
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
